// File: rtl/y_centroid_tracker_pkg.sv
// Shared definitions for the camera-domain centroid pipeline.
// Holds the camera coordinate widths used by the mask stage, this tracker
// and the baton tracker. Also holds the default active-area geometry and
// the centroid FSM state encoding.
package y_centroid_tracker_pkg;

  localparam int H_ACTIVE_DEFAULT = 1280;
  localparam int V_ACTIVE_DEFAULT = 720;

  localparam int HCOUNT_W = 11;  // pixel column width
  localparam int VCOUNT_W = 10;  // pixel row width
  localparam int Y_COM_W  = 11;  // centroid row as handed to the baton tracker
  localparam int DROP_W   = 8;   // dropped-frame counter width

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIVIDE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/y_centroid_tracker_if.sv
// Pixel-stream in / measurement out bundle of the y-centroid tracker.
//   valid_in, hcount_in, vcount_in, mask_in : qualified masked pixel stream
//   frame_done_in                           : one-cycle end-of-frame pulse
//   y_com_out, measure_out                  : centroid row and its update strobe
//   lost_out, busy_out, drop_count_out      : tracking status
// The master modport is the side that drives the pixels and consumes the
// result. The slave modport is the tracker itself.
interface y_centroid_tracker_if;
  import y_centroid_tracker_pkg::*;

  logic                valid_in;
  logic [HCOUNT_W-1:0] hcount_in;
  logic [VCOUNT_W-1:0] vcount_in;
  logic                mask_in;
  logic                frame_done_in;
  logic [Y_COM_W-1:0]  y_com_out;
  logic                measure_out;
  logic                lost_out;
  logic                busy_out;
  logic [DROP_W-1:0]   drop_count_out;

  modport master (
    output valid_in, hcount_in, vcount_in, mask_in, frame_done_in,
    input  y_com_out, measure_out, lost_out, busy_out, drop_count_out
  );

  modport slave (
    input  valid_in, hcount_in, vcount_in, mask_in, frame_done_in,
    output y_com_out, measure_out, lost_out, busy_out, drop_count_out
  );

endinterface

// File: rtl/y_centroid_tracker_seq_divider.sv
// Iterative restoring divider. It produces one quotient bit per cycle, MSB first.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : load dividend/divisor. Ignored while busy.
//   dividend  : DIVIDEND_W-bit numerator
//   divisor   : DIVISOR_W-bit denominator. The caller keeps this nonzero.
//   busy      : an iteration is in progress
//   done      : high during the final iteration. quotient is valid from the
//               following cycle and holds until the next start.
//   quotient  : floor(dividend / divisor)
module y_centroid_tracker_seq_divider #(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 21
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient
);

  localparam int IDX_W = $clog2(DIVIDEND_W);

  logic [DIVIDEND_W-1:0] dvd_q;   // remaining dividend bits, next bit at MSB
  logic [DIVISOR_W-1:0]  dvs_q;
  logic [DIVISOR_W-1:0]  rem_q;   // partial remainder, always < divisor
  logic [DIVIDEND_W-1:0] quo_q;
  logic [IDX_W-1:0]      idx_q;   // bit index being resolved
  logic                  busy_q;

  logic [DIVISOR_W:0] rem_shift;
  logic [DIVISOR_W:0] rem_diff;
  logic               fits;

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    rem_shift = {rem_q, dvd_q[DIVIDEND_W-1]};
    rem_diff  = rem_shift - {1'b0, dvs_q};
    // The partial remainder is below the divisor before the shift, so
    // rem_shift < 2*divisor. A borrow out of the MSB therefore means the
    // divisor did not fit.
    fits      = ~rem_diff[DIVISOR_W];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      idx_q  <= '0;
      busy_q <= 1'b0;
    end else if (start && !busy_q) begin
      dvd_q  <= dividend;
      dvs_q  <= divisor;
      rem_q  <= '0;
      quo_q  <= '0;
      idx_q  <= IDX_W'(DIVIDEND_W - 1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      dvd_q <= dvd_q << 1;
      quo_q <= {quo_q[DIVIDEND_W-2:0], fits};
      rem_q <= fits ? rem_diff[DIVISOR_W-1:0] : rem_shift[DIVISOR_W-1:0];
      if (idx_q == '0) busy_q <= 1'b0;
      else             idx_q  <= idx_q - IDX_W'(1);
    end
  end

  assign busy     = busy_q;
  assign done     = busy_q && (idx_q == '0);
  assign quotient = quo_q;

endmodule

// File: rtl/y_centroid_tracker.sv
// Vertical centre-of-mass of the masked pixels in each camera frame.
//   clk_camera_in : camera pixel clock
//   rst_in        : asynchronous active-high reset
//   bus (slave)   : pixel stream in; y_com/measure/lost/busy/drop_count out
// Per frame, the tracker sums the rows of qualifying pixels and counts them.
// On frame_done_in it hands the closing totals to a sequential divider and
// reports floor(sum/count), clamped to the active area. Accumulation of the
// next frame starts immediately. A frame that closes while a division is
// still running is counted as dropped.
module y_centroid_tracker
  import y_centroid_tracker_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE   = V_ACTIVE_DEFAULT,
  parameter int MIN_PIXELS = 16,
  parameter int SUM_W      = 32,
  parameter int CNT_W      = 21
) (
  input  logic          clk_camera_in,
  input  logic          rst_in,
  y_centroid_tracker_if.slave bus
);

  localparam logic [HCOUNT_W:0]  H_LIM   = (HCOUNT_W + 1)'(H_ACTIVE);
  localparam logic [VCOUNT_W:0]  V_LIM   = (VCOUNT_W + 1)'(V_ACTIVE);
  localparam logic [CNT_W-1:0]   MIN_CNT = CNT_W'(MIN_PIXELS);
  localparam logic [SUM_W-1:0]   Q_LIM   = SUM_W'(V_ACTIVE);
  localparam logic [Y_COM_W-1:0] Y_MAX   = Y_COM_W'(V_ACTIVE - 1);

  state_t               state_q;
  logic [SUM_W-1:0]     ysum_q, ysum_next;
  logic [CNT_W-1:0]     cnt_q, cnt_next;
  logic [SUM_W:0]       sum_ext;
  logic                 pix_hit;
  logic                 enough;
  logic                 div_start, div_busy, div_done;
  logic [SUM_W-1:0]     div_quotient;
  logic [Y_COM_W-1:0]   y_clamped;
  logic [Y_COM_W-1:0]   y_com_q;
  logic                 measure_q, lost_q, busy_q;
  logic [DROP_W-1:0]    drop_q;

  // The totals including this cycle's pixel. On a frame_done_in cycle this
  // value is the snapshot of the closing frame.
  always_comb begin
    pix_hit   = bus.valid_in && bus.mask_in &&
                ({1'b0, bus.hcount_in} < H_LIM) &&
                ({1'b0, bus.vcount_in} < V_LIM);
    sum_ext   = {1'b0, ysum_q} + (SUM_W + 1)'(bus.vcount_in);
    ysum_next = ysum_q;
    cnt_next  = cnt_q;
    if (pix_hit) begin
      ysum_next = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
      cnt_next  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    end
    // A zero count is always lost, so the divider never sees a zero divisor.
    enough    = (cnt_next >= MIN_CNT) && (cnt_next != '0);
    div_start = (state_q == ST_IDLE) && bus.frame_done_in && enough;
    y_clamped = (div_quotient < Q_LIM) ? div_quotient[Y_COM_W-1:0] : Y_MAX;
  end

  y_centroid_tracker_seq_divider #(
    .DIVIDEND_W (SUM_W),
    .DIVISOR_W  (CNT_W)
  ) u_div (
    .clk      (clk_camera_in),
    .rst      (rst_in),
    .start    (div_start),
    .dividend (ysum_next),
    .divisor  (cnt_next),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_ff @(posedge clk_camera_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      ysum_q    <= '0;
      cnt_q     <= '0;
      y_com_q   <= '0;
      measure_q <= 1'b0;
      lost_q    <= 1'b1;
      busy_q    <= 1'b0;
      drop_q    <= '0;
    end else begin
      measure_q <= 1'b0;

      if (bus.frame_done_in) begin
        ysum_q <= '0;
        cnt_q  <= '0;
      end else begin
        ysum_q <= ysum_next;
        cnt_q  <= cnt_next;
      end

      // Frames closing during DIVIDE or DONE are discarded here. The
      // running division is left alone.
      if (bus.frame_done_in && busy_q && !(&drop_q))
        drop_q <= drop_q + DROP_W'(1);

      case (state_q)
        ST_IDLE: begin
          if (bus.frame_done_in) begin
            if (enough) begin
              busy_q  <= 1'b1;
              state_q <= ST_DIVIDE;
            end else begin
              lost_q  <= 1'b1;
            end
          end
        end
        ST_DIVIDE: begin
          if (div_done) state_q <= ST_DONE;
        end
        ST_DONE: begin
          y_com_q   <= y_clamped;
          measure_q <= 1'b1;
          lost_q    <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The divider's own busy flag is covered by busy_q, which spans DIVIDE and DONE.
  logic unused_ok;
  assign unused_ok = div_busy;

  assign bus.y_com_out      = y_com_q;
  assign bus.measure_out    = measure_q;
  assign bus.lost_out       = lost_q;
  assign bus.busy_out       = busy_q;
  assign bus.drop_count_out = drop_q;

endmodule

// File: tb/tb_y_centroid_tracker.sv
// Self-checking bench for y_centroid_tracker.
// Directed frames cover these cases:
//   - reset values
//   - latency
//   - the minimum pixel count
//   - a pixel coincident with frame_done_in
//   - overrun
//   - out-of-range pixels
//   - reset during a division
// These are followed by randomized frames. The expected centroid comes from
// the list of rows the bench meant to be counted: floor(sum/size), clamped.
module tb_y_centroid_tracker;
  import y_centroid_tracker_pkg::*;

  localparam int H_ACT   = 1280;
  localparam int V_ACT   = 720;
  localparam int MIN_PIX = 16;
  localparam int SW      = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  y_centroid_tracker_if bus();

  y_centroid_tracker #(
    .H_ACTIVE   (H_ACT),
    .V_ACTIVE   (V_ACT),
    .MIN_PIXELS (MIN_PIX),
    .SUM_W      (SW),
    .CNT_W      (21)
  ) dut (
    .clk_camera_in (clk),
    .rst_in        (rst),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          pulses = 0;
  logic        prev_meas = 1'b0;
  int unsigned rows[$];         // rows intended to count in the open frame
  int          last_y = 0;      // y_com_out the bench expects to be held

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.measure_out === 1'b1) begin
      pulses++;
      check("no_back_to_back", prev_meas, 0);
    end
    prev_meas = bus.measure_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit valid, input bit mask, input int h, input int v, input bit fd);
    bus.valid_in      = valid;
    bus.mask_in       = mask;
    bus.hcount_in     = 11'(h);
    bus.vcount_in     = 10'(v);
    bus.frame_done_in = fd;
    tick();
    bus.valid_in      = 1'b0;
    bus.mask_in       = 1'b0;
    bus.frame_done_in = 1'b0;
  endtask

  task automatic good(input int v);
    drive(1, 1, $urandom_range(0, H_ACT - 1), v, 0);
    rows.push_back(v);
  endtask

  // A pixel that must not count, chosen from the four ways of not counting.
  task automatic noise();
    case ($urandom_range(0, 3))
      0: drive(0, 1, $urandom_range(0, H_ACT - 1), $urandom_range(0, V_ACT - 1), 0);
      1: drive(1, 0, $urandom_range(0, H_ACT - 1), $urandom_range(0, V_ACT - 1), 0);
      2: drive(1, 1, $urandom_range(H_ACT, 2047), $urandom_range(0, V_ACT - 1), 0);
      default: drive(1, 1, $urandom_range(0, 2047), $urandom_range(V_ACT, 1023), 0);
    endcase
  endtask

  task automatic close_frame(input bit with_pix, input int v,
                             output int t0, output longint e_cnt, output longint e_sum);
    if (with_pix) rows.push_back(v);
    e_cnt = rows.size();
    e_sum = 0;
    foreach (rows[i]) e_sum += rows[i];
    rows.delete();
    drive(with_pix, with_pix, with_pix ? $urandom_range(0, H_ACT - 1) : 0, v, 1);
    t0 = cyc;
  endtask

  function automatic int expected_y(input longint sum, input longint cnt);
    longint q;
    q = sum / cnt;
    return (q < V_ACT) ? int'(q) : V_ACT - 1;
  endfunction

  // Called right after the frame_done_in edge. It checks either a lost
  // frame or one strobe at the required latency carrying the expected row.
  task automatic finish_frame(input string tag, input int t0, input longint cnt, input longint sum);
    int p0;
    bit seen;
    int exp_y;
    p0 = pulses;
    if (cnt < MIN_PIX) begin
      check({tag, "_lost"}, bus.lost_out, 1);
      repeat (40) tick();
      check({tag, "_no_strobe"}, pulses - p0, 0);
      check({tag, "_y_held"}, bus.y_com_out, last_y);
      check({tag, "_still_lost"}, bus.lost_out, 1);
    end else begin
      exp_y = expected_y(sum, cnt);
      check({tag, "_busy"}, bus.busy_out, 1);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        tick();
        if (bus.measure_out === 1'b1) seen = 1'b1;
      end
      check({tag, "_strobe_seen"}, seen, 1);
      if (seen) begin
        check({tag, "_latency"}, cyc - t0 + 1, SW + 2);
        check({tag, "_y_com"}, bus.y_com_out, exp_y);
        check({tag, "_lost_clear"}, bus.lost_out, 0);
        check({tag, "_idle"}, bus.busy_out, 0);
        last_y = exp_y;
        tick();
        check({tag, "_single_pulse"}, bus.measure_out, 0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal;
  end

  initial begin
    int     t0, ta, tb_unused;
    longint c, s, ca, sa, cb, sb;
    int     p0, n;

    bus.valid_in = 0; bus.mask_in = 0; bus.hcount_in = 0;
    bus.vcount_in = 0; bus.frame_done_in = 0;
    repeat (3) tick();
    check("rst_y_com", bus.y_com_out, 0);
    check("rst_measure", bus.measure_out, 0);
    check("rst_lost", bus.lost_out, 1);
    check("rst_busy", bus.busy_out, 0);
    check("rst_drop", bus.drop_count_out, 0);
    rst = 1'b0;
    repeat (2) tick();

    // Rows 100,100,102,102 repeated to reach MIN_PIXELS: centroid 101.
    for (int i = 0; i < 4; i++) begin
      good(100); good(100); good(102); good(102);
    end
    close_frame(0, 0, t0, c, s);
    finish_frame("basic", t0, c, s);

    // One pixel short of the minimum, then a valid frame at row 500.
    for (int i = 0; i < MIN_PIX - 1; i++) good($urandom_range(0, V_ACT - 1));
    close_frame(0, 0, t0, c, s);
    finish_frame("short", t0, c, s);
    for (int i = 0; i < MIN_PIX; i++) good(500);
    close_frame(0, 0, t0, c, s);
    finish_frame("row500", t0, c, s);

    // Nineteen pixels at row 0 plus one at row 700 on the frame_done_in cycle.
    for (int i = 0; i < 19; i++) good(0);
    close_frame(1, 700, t0, c, s);
    check("coinc_model_sum", s, 700);
    finish_frame("coinc", t0, c, s);

    // Overrun: a second frame_done_in 10 cycles after the first.
    repeat (3) tick();
    for (int i = 0; i < MIN_PIX; i++) good(200);
    p0 = pulses;
    close_frame(0, 0, ta, ca, sa);
    for (int i = 0; i < 9; i++) good(600);
    close_frame(0, 0, tb_unused, cb, sb);
    check("ovr_drop", bus.drop_count_out, 1);
    finish_frame("ovr", ta, ca, sa);
    repeat (40) tick();
    check("ovr_one_pulse", pulses - p0, 1);
    for (int i = 0; i < 20; i++) good(300);
    close_frame(0, 0, t0, c, s);
    finish_frame("after_ovr", t0, c, s);

    // Masked pixels just outside the active area never count.
    for (int i = 0; i < 10; i++) drive(1, 1, H_ACT, $urandom_range(0, V_ACT - 1), 0);
    for (int i = 0; i < 10; i++) drive(1, 1, $urandom_range(0, H_ACT - 1), V_ACT, 0);
    close_frame(0, 0, t0, c, s);
    finish_frame("edge", t0, c, s);

    // Reset in the middle of a division.
    for (int i = 0; i < MIN_PIX; i++) good(400);
    close_frame(0, 0, t0, c, s);
    repeat (15) tick();
    check("mid_busy", bus.busy_out, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_y_com", bus.y_com_out, 0);
    check("mid_rst_lost", bus.lost_out, 1);
    check("mid_rst_busy", bus.busy_out, 0);
    check("mid_rst_drop", bus.drop_count_out, 0);
    rows.delete();
    last_y = 0;
    tick(); tick();
    rst = 1'b0;
    p0 = pulses;
    repeat (50) tick();
    check("mid_rst_no_strobe", pulses - p0, 0);
    for (int i = 0; i < 24; i++) good($urandom_range(0, V_ACT - 1));
    close_frame(0, 0, t0, c, s);
    finish_frame("post_rst", t0, c, s);

    // Randomized frames with interleaved non-counting pixels and idle cycles.
    for (int f = 0; f < 10; f++) begin
      n = $urandom_range(10, 60);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) noise();
        if ($urandom_range(0, 5) == 0) drive(0, 0, 0, 0, 0);
        good($urandom_range(0, V_ACT - 1));
      end
      close_frame($urandom_range(0, 1), $urandom_range(0, V_ACT - 1), t0, c, s);
      finish_frame($sformatf("rand%0d", f), t0, c, s);
      repeat ($urandom_range(0, 4)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/y_centroid_tracker.md
Name: y_centroid_tracker

Overview:
- Produces the `y_com_in` / `measure_in` pair that the baton derivative tracker consumes.
- Accumulates the vertical coordinate of every masked (baton-coloured) pixel in a camera frame.
- At frame end, computes the centre-of-mass y with an iterative restoring divider and emits one `measure_out` strobe with the result.
- Sits between the colour-threshold mask stage and the baton tracker, in the camera clock domain.

Parameters:
- H_ACTIVE, 1280, active pixels per line; pixels with hcount_in >= H_ACTIVE are ignored.
- V_ACTIVE, 720, active lines; pixels with vcount_in >= V_ACTIVE are ignored.
- MIN_PIXELS, 16, minimum masked-pixel count for a frame to produce a measurement.
- SUM_W, 32, width of the y-sum accumulator and of the divider dividend.
- CNT_W, 21, width of the pixel-count accumulator and of the divisor.

Ports:
- clk_camera_in  input  1  camera pixel clock.
- rst_in  input  1  asynchronous, active-high reset.
- valid_in  input  1  pixel qualifier for hcount_in / vcount_in / mask_in.
- hcount_in  input  11  pixel column.
- vcount_in  input  10  pixel row.
- mask_in  input  1  pixel belongs to the baton.
- frame_done_in  input  1  one-cycle pulse after the last active pixel of a frame.
- y_com_out  output  11  latest centroid row, zero-extended; held between updates.
- measure_out  output  1  one-cycle strobe; y_com_out is new in the same cycle.
- lost_out  output  1  high while the last completed frame had fewer than MIN_PIXELS masked pixels.
- busy_out  output  1  divider running.
- drop_count_out  output  8  frames discarded because the divider was busy; saturates at 255.

Behaviour:
- Reset is asynchronous and active-high: clock clk_camera_in, reset rst_in.
- Reset values: y_com_out=0, measure_out=0, lost_out=1, busy_out=0, drop_count_out=0, accumulators=0, FSM=IDLE.
- Accumulate stage:
  - A pixel counts when valid_in & mask_in & hcount_in<H_ACTIVE & vcount_in<V_ACTIVE.
  - Each counted pixel adds vcount_in to ysum (SUM_W bits) and 1 to cnt (CNT_W bits).
  - Both accumulators saturate at all-ones; no wrap.
- frame_done_in cycle:
  - A pixel qualifying in the same cycle is included in the closing frame.
  - The final ysum/cnt, including that pixel, are snapshotted and both accumulators clear to 0 on the next edge.
  - Accumulation of the next frame is therefore never stalled.
- FSM states: IDLE, DIVIDE, DONE.
- IDLE:
  - On frame_done_in with snapshot cnt < MIN_PIXELS: set lost_out=1, no strobe, y_com_out holds, stay IDLE.
  - Otherwise: load dividend=ysum and divisor=cnt, clear quotient/remainder, set bit index=SUM_W-1, busy_out=1, go to DIVIDE.
- DIVIDE:
  - One restoring-division bit per cycle, MSB first. Each cycle: rem = {rem,dividend[i]}; if rem >= divisor then subtract and set q[i].
  - After SUM_W cycles, go to DONE.
- DONE (one cycle):
  - y_com_out = q[10:0] if q < V_ACTIVE, else V_ACTIVE-1.
  - measure_out=1, lost_out=0, busy_out=0, return to IDLE.
- Latency: frame_done_in at cycle T gives measure_out at cycle T+SUM_W+2.
- measure_out is never high for two consecutive cycles.
- Overrun: frame_done_in while busy_out=1:
  - The snapshot is discarded and drop_count_out increments (saturating).
  - The running division completes unaffected.
  - Accumulators still clear.
- The quotient is truncated (floor), not rounded.
- Reset mid-division: all state returns to reset values immediately and no strobe is emitted.

Decomposition:
- Shared package holds:
  - The FSM state enum (IDLE/DIVIDE/DONE).
  - H_ACTIVE/V_ACTIVE defaults.
  - The camera coordinate widths (11/10), also used by the baton tracker and mask stage.
- One natural sub-module: seq_divider.
  - Parameterised restoring divider with start/busy/done handshake.
  - Dividend SUM_W bits, divisor CNT_W bits.
  - Reusable for the x-centroid later.

Test Plan:
- Single frame, 4 masked pixels at rows 100,100,102,102 with MIN_PIXELS=4 → y_com_out=101, measure_out pulses exactly once at T+34 (SUM_W=32).
- Frame with 15 masked pixels (MIN_PIXELS=16) → no measure_out, lost_out=1, y_com_out keeps its previous value; a following valid frame at row 500 → y_com_out=500, lost_out=0.
- Masked pixel coincident with frame_done_in at row 700, with earlier 19 pixels at row 0 → sum 700, cnt 20 → y_com_out=35.
- Second frame_done_in 10 cycles after the first → drop_count_out=1, only one measure_out, with the first frame's value; a third frame after completion is processed normally.
- Pixels at hcount=1280 or vcount=720 with mask set → ignored; a frame consisting only of these gives lost_out=1.
- Assert rst_in at cycle 15 of DIVIDE → outputs return immediately to reset values, no strobe follows, and the next frame measures correctly.
